// File: rtl/bus_arbiter8_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter8_if -- handshake/bus bundle between eight requesters, the
// arbiter and the downstream sink.
//   req       : per-requester request, bit i = requester i
//   in_data   : packed request lanes, requester i at [i*DATA_W +: DATA_W]
//   out_ready : sink accepts the current word
//   out_valid : out_data holds a granted word
//   out_data  : granted lane
//   sel       : index of the granted requester
//   grant     : one-hot grant, zero when idle
//   ack       : one-hot transfer pulse to the granted requester
// Modports: master = requesters/sink side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface bus_arbiter8_if #(
    parameter int DATA_W = 4
);
    logic [7:0]          req;
    logic [8*DATA_W-1:0] in_data;
    logic                out_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [2:0]          sel;
    logic [7:0]          grant;
    logic [7:0]          ack;

    modport master (
        output req, in_data, out_ready,
        input  out_valid, out_data, sel, grant, ack
    );

    modport slave (
        input  req, in_data, out_ready,
        output out_valid, out_data, sel, grant, ack
    );
endinterface

// File: rtl/bus_arbiter8.sv
// -----------------------------------------------------------------------------
// bus_arbiter8 -- 8-requester round-robin bus arbiter with an 8:1 data mux.
//   clk   : single clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bus_arbiter8_if.slave (req/in_data/out_ready in,
//           out_valid/out_data/sel/grant/ack out)
// Optional feature: define BUS_ARB_BURST_EN to let a requester keep its grant
// for up to BURST_LEN consecutive transfers while it keeps requesting.
// Without it every transfer releases the grant.
// -----------------------------------------------------------------------------
module bus_arbiter8 #(
    parameter int DATA_W    = 4,
    parameter int BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter8_if.slave bus
);
    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_sel;
    logic [7:0] r_grant;
    logic       r_valid;

`ifdef BUS_ARB_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    logic [BW-1:0] r_beats;
`endif

    logic       w_xfer;
    logic       w_keep;
    logic       w_any;
    logic [2:0] w_start;
    logic [2:0] w_idx;
    logic [2:0] w_win;

    assign w_xfer = r_valid & bus.out_ready;
    assign w_any  = |bus.req;

    // While granted the only arbitration that matters is the one on transfer,
    // which starts just past the served requester: it is scanned last, so it
    // wins again only if nobody else is requesting.
    assign w_start = (r_state == S_GRANT) ? r_sel + 3'd1 : r_ptr;

    // Descending scan so the lowest offset from w_start is the final write.
    always_comb begin
        w_win = w_start;
        w_idx = w_start;
        for (int k = 7; k >= 0; k--) begin
            w_idx = w_start + 3'(k);
            if (bus.req[w_idx]) w_win = w_idx;
        end
    end

`ifdef BUS_ARB_BURST_EN
    // Stay on the current requester while it still asks and the beat budget
    // is not yet spent (r_beats counts completed transfers minus one).
    assign w_keep = bus.req[r_sel] & (r_beats < BW'(BURST_LEN - 1));
`else
    assign w_keep = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'd0;
            r_sel   <= 3'd0;
            r_grant <= 8'd0;
            r_valid <= 1'b0;
`ifdef BUS_ARB_BURST_EN
            r_beats <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_win;
                        r_grant <= 8'd1 << w_win;
                        r_valid <= 1'b1;
                        r_state <= S_GRANT;
`ifdef BUS_ARB_BURST_EN
                        r_beats <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    if (w_xfer && w_keep) begin
`ifdef BUS_ARB_BURST_EN
                        r_beats <= r_beats + 1'b1;
`endif
                    end else if (w_xfer) begin
                        // Release and hand over with no idle bubble.
                        r_ptr <= r_sel + 3'd1;
                        if (w_any) begin
                            r_sel   <= w_win;
                            r_grant <= 8'd1 << w_win;
`ifdef BUS_ARB_BURST_EN
                            r_beats <= '0;
`endif
                        end else begin
                            r_grant <= 8'd0;
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (!bus.req[r_sel]) begin
                        // Requester withdrew before being served: no ack,
                        // pointer untouched, arbitrate again from IDLE.
                        r_grant <= 8'd0;
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.sel       = r_sel;
    assign bus.grant     = r_grant;
    assign bus.out_data  = bus.in_data[r_sel*DATA_W +: DATA_W];
    assign bus.ack       = r_grant & {8{r_valid & bus.out_ready}};
endmodule

// File: tb/tb_bus_arbiter8.sv
module tb_bus_arbiter8;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_arbiter8_if #(.DATA_W(DW)) bus ();

    bus_arbiter8 #(.DATA_W(DW), .BURST_LEN(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string      tag;
        bit         chk_sel;
        logic [2:0] sel;
        logic [7:0] grant;
        logic       valid;
        logic [7:0] ack;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [3:0]  lanes[8] = '{4'd12, 4'd15, 4'd1, 4'd3, 4'd5, 4'd2, 4'd11, 4'd14};
    int          bseq[$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(string tag, bit cs, logic [2:0] s, logic [7:0] g, logic v, logic [7:0] a);
        exp_t e;
        e.tag = tag; e.chk_sel = cs; e.sel = s; e.grant = g; e.valid = v; e.ack = a;
        sb.push_back(e);
    endtask

    task automatic cmp(string tag, string f, logic [7:0] got, logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s.%s got=%0h exp=%0h", tag, f, got, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard underflow");
            return;
        end
        e = sb.pop_front();
        cmp(e.tag, "valid", {7'd0, bus.out_valid}, {7'd0, e.valid});
        cmp(e.tag, "grant", bus.grant, e.grant);
        cmp(e.tag, "ack", bus.ack, e.ack);
        if (e.chk_sel) begin
            cmp(e.tag, "sel", {5'd0, bus.sel}, {5'd0, e.sel});
            if (e.valid) cmp(e.tag, "data", {4'd0, bus.out_data}, {4'd0, lanes[e.sel]});
        end
    endtask

    initial begin
        logic [7:0] m;
        rst_n         = 1'b0;
        bus.req       = 8'h00;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) bus.in_data[i*DW +: DW] = lanes[i];
        tick(); tick();

        // Reset state
        push("reset", 1, 3'd0, 8'h00, 1'b0, 8'h00); check_out();

        // Single requester 3, first edge after release arbitrates
        rst_n = 1'b1; bus.req = 8'h08;
        push("t1_grant", 1, 3'd3, 8'h08, 1'b1, 8'h08); tick(); check_out();
        bus.req = 8'h00;
        push("t1_idle", 0, 3'd0, 8'h00, 1'b0, 8'h00); tick(); check_out();

        // Full round robin from ptr=0, no bubbles
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            m = 8'h01 << (i % 8);
            push($sformatf("t2_rr%0d", i), 1, 3'(i % 8), m, 1'b1, m);
            tick(); check_out();
        end
        bus.req = 8'h00;   // last transfer of 0 -> ptr=1, idle
        push("t2_idle", 0, 3'd0, 8'h00, 1'b0, 8'h00); tick(); check_out();

        // Backpressure on requesters 2,5
        bus.req = 8'h24; bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push($sformatf("t3_hold%0d", i), 1, 3'd2, 8'h04, 1'b1, 8'h00);
            tick(); check_out();
        end
        bus.out_ready = 1'b1; #1;
        push("t3_ack", 1, 3'd2, 8'h04, 1'b1, 8'h04); check_out();
        push("t3_next", 1, 3'd5, 8'h20, 1'b1, 8'h20); tick(); check_out();
        bus.req = 8'h00;   // ptr -> 6
        push("t3_idle", 0, 3'd0, 8'h00, 1'b0, 8'h00); tick(); check_out();

        // Requester 7 withdraws before being served
        bus.req = 8'h81; bus.out_ready = 1'b0;
        push("t4_g7", 1, 3'd7, 8'h80, 1'b1, 8'h00); tick(); check_out();
        bus.req = 8'h01;
        push("t4_drop", 0, 3'd0, 8'h00, 1'b0, 8'h00); tick(); check_out();
        push("t4_g0", 1, 3'd0, 8'h01, 1'b1, 8'h00); tick(); check_out();

        // Async reset mid-grant on requester 6
        bus.req = 8'h40;
        push("t5_drop0", 0, 3'd0, 8'h00, 1'b0, 8'h00); tick(); check_out();
        push("t5_g6", 1, 3'd6, 8'h40, 1'b1, 8'h00); tick(); check_out();
        #2; rst_n = 1'b0; bus.out_ready = 1'b1; #1;
        push("t5_async", 1, 3'd0, 8'h00, 1'b0, 8'h00); check_out();
        tick();
        bus.req = 8'h00; rst_n = 1'b1;
        push("t5_post", 1, 3'd0, 8'h00, 1'b0, 8'h00); tick(); check_out();

        // Requesters 0 and 6 held
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        bus.req = 8'h41; bus.out_ready = 1'b1;
`ifdef BUS_ARB_BURST_EN
        bseq = '{0, 0, 0, 0, 6, 6, 6, 6, 0};
`else
        bseq = '{0, 6, 0, 6, 0};
`endif
        foreach (bseq[i]) begin
            m = 8'h01 << bseq[i];
            push($sformatf("t6_b%0d", i), 1, 3'(bseq[i]), m, 1'b1, m);
            tick(); check_out();
        end
        bus.req = 8'h00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_arbiter8.md
BUS_ARBITER8 -- requirements
Module: bus_arbiter8

Interface
REQ-001 SHALL have parameter DATA_W, default 4, width of each requester data lane.
REQ-002 SHALL have parameter BURST_LEN, default 4, max consecutive transfers per grant (used only with BUS_ARB_BURST_EN).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  8  per-requester request, bit i = requester i.
REQ-006 SHALL have port in_data  input  8*DATA_W  packed lanes, requester i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port out_ready  input  1  downstream sink accepts data.
REQ-008 SHALL have port out_valid  output  1  out_data holds a granted word.
REQ-009 SHALL have port out_data  output  DATA_W  lane selected by sel, combinational from in_data.
REQ-010 SHALL have port sel  output  3  registered index of granted requester (drives the 8:1 bus mux).
REQ-011 SHALL have port grant  output  8  registered one-hot grant, all zero when idle.
REQ-012 SHALL have port ack  output  8  one-hot pulse, ack[i] = grant[i] & out_valid & out_ready.

Function
REQ-013 SHALL implement two states: IDLE (no grant) and GRANT (one requester granted, out_valid=1).
REQ-014 SHALL keep a 3-bit round-robin pointer ptr; winner = first i with req[i]=1 scanning ptr, ptr+1, ... mod 8.
REQ-015 SHALL in IDLE with any req set: register winner into sel/grant, enter GRANT next cycle (1-cycle request-to-grant latency).
REQ-016 SHALL drive out_valid=1 exactly while in GRANT; out_data = in_data lane sel.
REQ-017 SHALL count a transfer when out_valid & out_ready at a rising edge.
REQ-018 SHALL on transfer set ptr = sel+1 (wrap 7->0) and re-arbitrate in the same cycle: new winner granted next cycle with no bubble; if no req pending, enter IDLE.
REQ-019 SHALL exclude the just-served requester from winning again while any other req is set (fairness); it may win again if it is the only requester.
REQ-020 SHALL, if req[sel] drops while in GRANT without transfer, drop grant next cycle, emit no ack, leave ptr unchanged and re-arbitrate from ptr.
REQ-021 SHALL hold sel, grant and out_valid stable while out_ready=0 (no reassignment during backpressure).
REQ-022 SHALL ignore in_data changes on non-granted lanes; granted requester holds its lane until ack.

Reset
REQ-023 SHALL, while rst_n=0, force state=IDLE, ptr=0, sel=0, grant=0, out_valid=0, ack=0, beat counter=0, independent of clk.
REQ-024 SHALL abort an in-progress grant on reset with no ack; first arbitration after release starts at ptr=0.
REQ-025 SHALL leave the first rising edge after rst_n deassertion as a normal arbitration edge.

Configuration
REQ-026 SHALL support macro BUS_ARB_BURST_EN.
REQ-027 SHALL, with BUS_ARB_BURST_EN defined, keep the grant after a transfer if req[sel] is still 1 and fewer than BURST_LEN transfers have completed in this grant; ptr advances only when the grant is released.
REQ-028 SHALL, with BUS_ARB_BURST_EN defined, reset the beat counter on every new grant and release after the BURST_LEN-th transfer even if req[sel]=1.
REQ-029 SHALL, without BUS_ARB_BURST_EN, release after every transfer (burst length 1) and omit the beat counter logic.

Verification
REQ-030 SHALL cover: reset, then lanes 0..7 = 12,15,1,3,5,2,11,14, req=8'h08, out_ready=1 -> next cycle sel=3, grant=8'h08, out_data=3, ack[3] pulse.
REQ-031 SHALL cover: req=8'hFF held, out_ready=1, no burst -> sel sequence 0,1,2,...,7,0 one per cycle, out_data 12,15,1,3,5,2,11,14,12.
REQ-032 SHALL cover: req=8'h24 (requesters 2,5), out_ready=0 for 5 cycles -> sel=2, out_data=1 stable, no ack; then out_ready=1 -> ack[2], next sel=5, out_data=2.
REQ-033 SHALL cover: granted requester 7 drops req before out_ready -> grant=0 next cycle, no ack, ptr unchanged, pending req 0 then wins with out_data=12.
REQ-034 SHALL cover: rst_n pulsed low mid-GRANT (sel=6) -> out_valid, grant, sel 0 immediately without clk edge, no ack[6].
REQ-035 SHALL cover, BUS_ARB_BURST_EN, BURST_LEN=4: req=8'h41 held, out_ready=1 -> sel 0 for 4 transfers, then 6 for 4, then 0.
